heap_array_allocator: RTL and testbench

//  Parametrised hardware heap for the zero VM: owns N_ARRAYS fixed-size areas of N_AREA words each.

---
 rtl/heap_array_allocator.sv | 267 ++++++++++++++++++++++++++
 tb/tb_heap_array_allocator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/heap_array_allocator.sv
// ---------------------------------------------------------------------------
// heap_array_allocator
//
// Hardware heap for the zero VM. Owns N_ARRAYS fixed-size areas of N_AREA
// words each and executes one array operation at a time behind a valid/ready
// request port. Freed array ids are recycled through a LIFO stack. A
// high-water count of fresh allocations is kept next to the live count.
//
// Ports
//   clock      in   1        rising-edge clock
//   reset      in   1        asynchronous, active-low
//   req_valid  in   1        request present
//   req_ready  out  1        block can accept a request (registered)
//   req_op     in   3        0 ARRAY 1 FREE 2 READ 3 WRITE 4 PUSH 5 POP 6 SIZE
//   req_array  in   AW       target array id (ignored for ARRAY)
//   req_index  in   IW       element index (READ/WRITE)
//   req_data   in   WIDTH    write/push data
//   rsp_valid  out  1        one-cycle result pulse
//   rsp_data   out  WIDTH    id, read/pop value or size; 0 otherwise
//   rsp_error  out  3        0 OK 1 FULL 2 EMPTY 3 BOUND 4 BADARR 5 BADOP
//   allocs     out  AW+1     high-water count of fresh allocations
//   live       out  AW+1     arrays currently allocated
// ---------------------------------------------------------------------------
module heap_array_allocator #(
  parameter int WIDTH    = 12,
  parameter int N_ARRAYS = 20,
  parameter int N_AREA   = 10,
  localparam int AW      = $clog2(N_ARRAYS),
  localparam int IW      = $clog2(N_AREA + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [AW-1:0]    req_array,
  input  logic [IW-1:0]    req_index,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_error,
  output logic [AW:0]      allocs,
  output logic [AW:0]      live
);

  localparam int DEPTH = N_ARRAYS * N_AREA;
  localparam int HAW   = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ARRAY = 3'd0,
    OP_FREE  = 3'd1,
    OP_READ  = 3'd2,
    OP_WRITE = 3'd3,
    OP_PUSH  = 3'd4,
    OP_POP   = 3'd5,
    OP_SIZE  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam logic [2:0] ERR_OK     = 3'd0;
  localparam logic [2:0] ERR_FULL   = 3'd1;
  localparam logic [2:0] ERR_EMPTY  = 3'd2;
  localparam logic [2:0] ERR_BOUND  = 3'd3;
  localparam logic [2:0] ERR_BADARR = 3'd4;
  localparam logic [2:0] ERR_BADOP  = 3'd5;

  state_e            state_q;
  logic              reqReady_q;
  logic              rspValid_q;
  logic [WIDTH-1:0]  rspData_q;
  logic [2:0]        rspError_q;
  logic [AW:0]       allocs_q;
  logic [AW:0]       live_q;

  op_e               op_q;
  logic [AW-1:0]     array_q;
  logic [IW-1:0]     index_q;
  logic [WIDTH-1:0]  data_q;

  logic [AW:0]       stackTop_q;
  logic [AW-1:0]     stack_q [N_ARRAYS];
  logic [N_ARRAYS-1:0] inUse_q;
  logic [IW-1:0]     sizes_q [N_ARRAYS];

  logic [WIDTH-1:0]  heapMem [DEPTH];

  logic              arrInRange;
  logic [AW-1:0]     arrIdx;
  logic              arrOk;
  logic [IW-1:0]     curSize;
  logic [2:0]        errCode;
  logic [IW-1:0]     offset;
  logic              heapWe;
  logic [AW-1:0]     allocId;
  logic              fromStack;
  logic [HAW-1:0]    heapAddr;

  // Decode of the latched request during EXEC: error classification, the
  // heap word touched, and the id an ARRAY op would hand out. Out-of-range
  // ids are folded onto id 0 for indexing and then rejected by arrOk.
  always_comb begin
    arrInRange = (array_q < AW'(N_ARRAYS));
    arrIdx     = arrInRange ? array_q : '0;
    arrOk      = arrInRange && inUse_q[arrIdx];
    curSize    = sizes_q[arrIdx];
    errCode    = ERR_OK;
    offset     = '0;
    heapWe     = 1'b0;
    allocId    = '0;
    fromStack  = 1'b0;
    case (op_q)
      OP_ARRAY: begin
        if (stackTop_q != '0) begin
          fromStack = 1'b1;
          allocId   = stack_q[stackTop_q[AW-1:0] - 1'b1];
        end else if (allocs_q < (AW+1)'(N_ARRAYS)) begin
          allocId = allocs_q[AW-1:0];
        end else begin
          errCode = ERR_FULL;
        end
      end
      OP_FREE: begin
        if (!arrOk) errCode = ERR_BADARR;
      end
      OP_READ, OP_WRITE: begin
        if (!arrOk) begin
          errCode = ERR_BADARR;
        end else if (index_q >= IW'(N_AREA)) begin
          errCode = ERR_BOUND;
        end else begin
          offset = index_q;
          heapWe = (op_q == OP_WRITE);
        end
      end
      OP_PUSH: begin
        if (!arrOk) begin
          errCode = ERR_BADARR;
        end else if (curSize == IW'(N_AREA)) begin
          errCode = ERR_FULL;
        end else begin
          offset = curSize;
          heapWe = 1'b1;
        end
      end
      OP_POP: begin
        if (!arrOk) begin
          errCode = ERR_BADARR;
        end else if (curSize == '0) begin
          errCode = ERR_EMPTY;
        end else begin
          offset = curSize - 1'b1;
        end
      end
      OP_SIZE: begin
        if (!arrOk) errCode = ERR_BADARR;
      end
      default: errCode = ERR_BADOP;
    endcase
    // Product is formed at full heap-address width so the base never wraps.
    heapAddr = HAW'(arrIdx) * HAW'(N_AREA) + HAW'(offset);
  end

  // Heap storage carries no reset; only successful WRITE/PUSH reach it.
  always_ff @(posedge clock) begin
    if (state_q == EXEC && heapWe) begin
      heapMem[heapAddr] <= data_q;
    end
  end

  // Control FSM with all bookkeeping and registered outputs. Errors commit
  // nothing but the response, so the success path is gated on ERR_OK.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      reqReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspError_q <= ERR_OK;
      allocs_q   <= '0;
      live_q     <= '0;
      op_q       <= OP_ARRAY;
      array_q    <= '0;
      index_q    <= '0;
      data_q     <= '0;
      stackTop_q <= '0;
      inUse_q    <= '0;
      for (int i = 0; i < N_ARRAYS; i++) begin
        stack_q[i] <= '0;
        sizes_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          rspValid_q <= 1'b0;
          if (req_valid && reqReady_q) begin
            op_q       <= op_e'(req_op);
            array_q    <= req_array;
            index_q    <= req_index;
            data_q     <= req_data;
            reqReady_q <= 1'b0;
            state_q    <= EXEC;
          end else begin
            reqReady_q <= 1'b1;
          end
        end
        EXEC: begin
          state_q    <= RESP;
          rspValid_q <= 1'b1;
          rspError_q <= errCode;
          rspData_q  <= '0;
          if (errCode == ERR_OK) begin
            case (op_q)
              OP_ARRAY: begin
                if (fromStack) stackTop_q <= stackTop_q - 1'b1;
                else           allocs_q   <= allocs_q + 1'b1;
                inUse_q[allocId] <= 1'b1;
                sizes_q[allocId] <= '0;
                live_q           <= live_q + 1'b1;
                rspData_q        <= WIDTH'(allocId);
              end
              OP_FREE: begin
                inUse_q[arrIdx]                 <= 1'b0;
                stack_q[stackTop_q[AW-1:0]]     <= arrIdx;
                stackTop_q                      <= stackTop_q + 1'b1;
                live_q                          <= live_q - 1'b1;
              end
              OP_READ: rspData_q <= heapMem[heapAddr];
              OP_PUSH: sizes_q[arrIdx] <= curSize + 1'b1;
              OP_POP: begin
                sizes_q[arrIdx] <= curSize - 1'b1;
                rspData_q       <= heapMem[heapAddr];
              end
              OP_SIZE: rspData_q <= WIDTH'(curSize);
              default: ;
            endcase
          end
        end
        RESP: begin
          rspValid_q <= 1'b0;
          rspData_q  <= '0;
          rspError_q <= ERR_OK;
          reqReady_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b0;
          rspValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign rsp_error = rspError_q;
  assign allocs    = allocs_q;
  assign live      = live_q;

endmodule

// File: tb/tb_heap_array_allocator.sv
// ---------------------------------------------------------------------------
// tb_heap_array_allocator
//
// Directed bench for heap_array_allocator with hand-computed expectations:
// allocation, reuse, push/pop/size, capacity limits, error codes, response
// latency and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_heap_array_allocator;

  localparam int WIDTH = 12;
  localparam int AW    = 5;
  localparam int IW    = 4;

  localparam int OK = 0, FULL = 1, EMPTY = 2, BOUND = 3, BADARR = 4, BADOP = 5;
  localparam int OP_ARRAY = 0, OP_FREE = 1, OP_READ = 2, OP_WRITE = 3;
  localparam int OP_PUSH = 4, OP_POP = 5, OP_SIZE = 6, OP_RSVD = 7;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = '0;
  logic [AW-1:0]    req_array = '0;
  logic [IW-1:0]    req_index = '0;
  logic [WIDTH-1:0] req_data = '0;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_error;
  logic [AW:0]      allocs;
  logic [AW:0]      live;

  int checkCount = 0;
  int errorCount = 0;

  heap_array_allocator #(.WIDTH(12), .N_ARRAYS(20), .N_AREA(10)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_array (req_array),
    .req_index (req_index),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .allocs    (allocs),
    .live      (live)
  );

  always #5 clock = ~clock;

  // Hard stop in case the handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Issues one request and waits for its response. Latency counts the
  // accepting cycle as cycle 0, so the response should land in cycle 2.
  task automatic applyStimulus(input int op, input int arr, input int idx, input int data,
                               output int rdata, output int rerr, output int lat);
    int waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(posedge clock); #1;
      waitCnt++;
    end
    if (!req_ready) begin
      checkOutput("readyWait", 0, 1);
      rdata = 0; rerr = 7; lat = 99;
      return;
    end
    req_op    = op[2:0];
    req_array = arr[AW-1:0];
    req_index = idx[IW-1:0];
    req_data  = data[WIDTH-1:0];
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!rsp_valid) lat = 99;
    rdata = int'(rsp_data);
    rerr  = int'(rsp_error);
  endtask

  task automatic runOp(input string tag, input int op, input int arr, input int idx,
                       input int data, input int expErr, input int expData);
    int rd, re, lat;
    applyStimulus(op, arr, idx, data, rd, re, lat);
    checkOutput({tag, ".err"}, re, expErr);
    checkOutput({tag, ".data"}, rd, expData);
    checkOutput({tag, ".lat"}, lat, 2);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst.ready", int'(req_ready), 0);
    checkOutput("rst.rspValid", int'(rsp_valid), 0);
    checkOutput("rst.allocs", int'(allocs), 0);
    checkOutput("rst.live", int'(live), 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("rst.readyAfter", int'(req_ready), 1);
  endtask

  initial begin
    applyReset();

    // 1: allocate, write, read back; response pulse lasts one cycle.
    runOp("t1.array", OP_ARRAY, 0, 0, 0, OK, 0);
    runOp("t1.write", OP_WRITE, 0, 2, 3, OK, 0);
    runOp("t1.read", OP_READ, 0, 2, 0, OK, 3);
    @(posedge clock); #1;
    checkOutput("t1.pulse", int'(rsp_valid), 0);

    // 2: second array, free id 0, id 0 comes back from the freed stack.
    runOp("t2.array1", OP_ARRAY, 0, 0, 0, OK, 1);
    runOp("t2.free0", OP_FREE, 0, 0, 0, OK, 0);
    runOp("t2.reuse", OP_ARRAY, 0, 0, 0, OK, 0);
    checkOutput("t2.allocs", int'(allocs), 2);
    checkOutput("t2.live", int'(live), 2);

    // 3: stack semantics on array 0 (size was cleared on reallocation).
    runOp("t3.push5", OP_PUSH, 0, 0, 5, OK, 0);
    runOp("t3.push6", OP_PUSH, 0, 0, 6, OK, 0);
    runOp("t3.push7", OP_PUSH, 0, 0, 7, OK, 0);
    runOp("t3.size3", OP_SIZE, 0, 0, 0, OK, 3);
    runOp("t3.pop", OP_POP, 0, 0, 0, OK, 7);
    runOp("t3.size2", OP_SIZE, 0, 0, 0, OK, 2);
    for (int i = 0; i < 10; i++) begin
      runOp($sformatf("t3.fill%0d", i), OP_PUSH, 0, 0, 100 + i, (i < 8) ? OK : FULL, 0);
    end
    runOp("t3.sizeFull", OP_SIZE, 0, 0, 0, OK, 10);
    runOp("t3.popTop", OP_POP, 0, 0, 0, OK, 107);
    runOp("t3.readBottom", OP_READ, 0, 0, 0, OK, 5);
    checkOutput("t3.live", int'(live), 2);

    // 4: exhaust capacity from a clean state, then double free and LIFO reuse.
    applyReset();
    for (int i = 0; i < 21; i++) begin
      runOp($sformatf("t4.array%0d", i), OP_ARRAY, 0, 0, 0, (i < 20) ? OK : FULL, (i < 20) ? i : 0);
    end
    checkOutput("t4.allocs", int'(allocs), 20);
    checkOutput("t4.live", int'(live), 20);
    runOp("t4.free3", OP_FREE, 3, 0, 0, OK, 0);
    runOp("t4.free3again", OP_FREE, 3, 0, 0, BADARR, 0);
    checkOutput("t4.liveAfterFree", int'(live), 19);
    runOp("t4.free5", OP_FREE, 5, 0, 0, OK, 0);
    runOp("t4.free7", OP_FREE, 7, 0, 0, OK, 0);
    runOp("t4.reuse7", OP_ARRAY, 0, 0, 0, OK, 7);
    runOp("t4.reuse5", OP_ARRAY, 0, 0, 0, OK, 5);
    runOp("t4.reuse3", OP_ARRAY, 0, 0, 0, OK, 3);
    runOp("t4.fullAgain", OP_ARRAY, 0, 0, 0, FULL, 0);
    checkOutput("t4.allocsHigh", int'(allocs), 20);
    checkOutput("t4.liveAll", int'(live), 20);

    // 5: error codes leave state untouched; last valid index still works.
    runOp("t5.write9", OP_WRITE, 0, 9, 'hABC, OK, 0);
    runOp("t5.read9", OP_READ, 0, 9, 0, OK, 'hABC);
    runOp("t5.bound", OP_READ, 0, 10, 0, BOUND, 0);
    runOp("t5.boundWr", OP_WRITE, 0, 10, 1, BOUND, 0);
    runOp("t5.empty", OP_POP, 0, 0, 0, EMPTY, 0);
    runOp("t5.badop", OP_RSVD, 0, 0, 0, BADOP, 0);
    runOp("t5.badId", OP_READ, 25, 0, 0, BADARR, 0);
    runOp("t5.size0", OP_SIZE, 0, 0, 0, OK, 0);
    runOp("t5.read9kept", OP_READ, 0, 9, 0, OK, 'hABC);
    checkOutput("t5.allocs", int'(allocs), 20);
    checkOutput("t5.live", int'(live), 20);

    // 6: reset while a PUSH is in EXEC; it must vanish without a response.
    begin
      int waitCnt = 0;
      while (!req_ready && waitCnt < 20) begin
        @(posedge clock); #1;
        waitCnt++;
      end
      checkOutput("t6.readyBefore", int'(req_ready), 1);
      req_op = 3'(OP_PUSH); req_array = '0; req_index = '0; req_data = 12'd42;
      req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("t6.noRsp0", int'(rsp_valid), 0);
      checkOutput("t6.readyInReset", int'(req_ready), 0);
      @(posedge clock); #1;
      checkOutput("t6.noRsp1", int'(rsp_valid), 0);
      checkOutput("t6.liveCleared", int'(live), 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      checkOutput("t6.readyAfter", int'(req_ready), 1);
      checkOutput("t6.noRsp2", int'(rsp_valid), 0);
    end
    runOp("t6.staleId", OP_SIZE, 0, 0, 0, BADARR, 0);
    runOp("t6.array", OP_ARRAY, 0, 0, 0, OK, 0);
    checkOutput("t6.allocs", int'(allocs), 1);
    checkOutput("t6.live", int'(live), 1);
    runOp("t6.sizeNew", OP_SIZE, 0, 0, 0, OK, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
